dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the data memory wrapper (`mem_*` interface with registered `valid`).
- Port 0: pipeline load/store unit. Port 1: auxiliary master (program loader or debug).
- Accepts one request at a time and drives a single-cycle memory access. For loads, waits for the memory's registered valid, then returns a one-cycle response to the requester that owns the access.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 32, data width; mask width is DATA_W/8.
- TIMEOUT, 15, max cycles in WAIT before an error response is forced; must be at least 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rN_req_valid  input  1  request from port N (N=0,1)
- rN_req_ready  output  1  request accepted this cycle
- rN_we  input  1  1=store, 0=load
- rN_mask  input  DATA_W/8  byte-enable for stores
- rN_addr  input  ADDR_W  word address
- rN_wdata  input  DATA_W  store data
- rN_rsp_valid  output  1  one-cycle response pulse
- rN_rsp_err  output  1  qualifies rsp_valid; load timed out
- rN_rdata  output  DATA_W  load data, valid with rsp_valid
- mem_we_re  output  1  write enable to memory
- mem_request  output  1  memory access strobe
- mem_load  output  1  load marker; memory returns valid one cycle later
- mem_mask  output  DATA_W/8  byte-enable
- mem_address  output  ADDR_W  word address
- mem_data_in  output  DATA_W  write data
- mem_valid  input  1  registered load-valid from memory
- mem_data_out  input  DATA_W  memory read data

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; command register, rdata registers and timeout counter cleared; RR pointer=1. Any in-flight access is aborted with no response. A mem_valid arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitrate among asserted rN_req_valid.
  - The winner gets rN_req_ready=1 combinationally in the same cycle, and its we/mask/addr/wdata plus owner ID are latched.
  - Next state: ISSUE. Ready is never asserted outside IDLE and never to both ports.
- ISSUE (exactly 1 cycle):
  - mem_request=1, mem_we_re=we, mem_load=~we; mem_mask/address/data_in come from the latch.
  - Store goes to RESP; load goes to WAIT with counter=0.
- WAIT:
  - mem_valid=1: capture mem_data_out into the owner's rdata, then go to RESP with err=0.
  - Otherwise increment the counter. When counter reaches TIMEOUT-1, go to RESP with err=1 and rdata=0.
- RESP (1 cycle): owner's rsp_valid=1, rsp_err as set; then IDLE.
- Latency from accept: store ack 2 cycles later, load response 3 cycles later (memory valid lands in the first WAIT cycle). Back-to-back throughput: store every 3 cycles, load every 4.
- Outside ISSUE: mem_request/mem_we_re/mem_load are 0. mem_address/mask/data_in hold their last values.
- rN_rdata holds until the next load response to that port. rsp_valid is never asserted to the non-owner.
- mem_valid outside WAIT is ignored.
- Store with mask=0 is still issued and acknowledged.
- A requester dropping req_valid after acceptance has no effect on the access.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: round-robin on a tie. The port not granted last wins; the pointer updates on every grant. After reset, port 0 wins the first tie.
- Undefined: fixed priority, port 0 always wins a tie; the pointer logic is absent.

Decomposition:
- Shared package dmem_arb_pkg contains:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - port ID constants PORT_LSU=0, PORT_AUX=1
  - packed command struct {owner, we, mask, addr, wdata}
- One sub-module, dmem_rr_arbiter: 2-way grant logic with pointer, selected by DMEM_ARB_RR_EN.

Test Plan:
- Port 0 store addr=8'h10, wdata=32'hDEADBEEF, mask=4'hF → ready in accept cycle; mem_request=mem_we_re=1 next cycle; r0_rsp_valid 2 cycles after accept, err=0.
- Port 1 load addr=8'h10 after that store, memory model with valid one cycle after load → r1_rsp_valid 3 cycles after accept, r1_rdata=32'hDEADBEEF, r0_rsp_valid stays 0.
- Both ports request every cycle for 4 grants → with RR_EN grants are 0,1,0,1; without RR_EN grants are 0,0,0,0 while port 1 is starved.
- Load with mem_valid forced 0, TIMEOUT=15 → rsp_valid=1, rsp_err=1, rdata=0 after 15 WAIT cycles; the next request is accepted normally.
- Assert rst during WAIT → all outputs 0 asynchronously; no rsp_valid; a late mem_valid is ignored; state IDLE after release.
- Store mask=4'b0101 wdata=32'hAABBCCDD to addr=8'h20, then load → mem_mask=4'b0101 during ISSUE; bytes 1 and 3 keep their prior contents in the read data.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int CMD_ADDR_W = 8;
    localparam int CMD_DATA_W = 32;

    localparam logic PORT_LSU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic                      owner;
        logic                      we;
        logic [CMD_DATA_W/8-1:0]   mask;
        logic [CMD_ADDR_W-1:0]     addr;
        logic [CMD_DATA_W-1:0]     wdata;
    } cmd_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter.
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = CMD_ADDR_W,
    parameter int DATA_W = CMD_DATA_W
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  we;
    logic [DATA_W/8-1:0]   mask;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req_valid, we, mask, addr, wdata,
        input  req_ready, rsp_valid, rsp_err, rdata
    );

    modport slave (
        input  req_valid, we, mask, addr, wdata,
        output req_ready, rsp_valid, rsp_err, rdata
    );
endinterface

// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter: 2-way grant logic for the data-memory arbiter.
// DMEM_ARB_RR_EN defined: round-robin on a tie (port not granted last wins).
// DMEM_ARB_RR_EN undefined: fixed priority, port 0 wins a tie.
module dmem_rr_arbiter
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);
`ifdef DMEM_ARB_RR_EN
    logic last_q;

    // Tie goes to the port that did not win the previous grant.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_q == PORT_AUX) ? 2'b01 : 2'b10;
        end
    end

    // Remember the most recent winner; reset makes port 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_AUX;
        end else if (grant_en && (req != 2'b00)) begin
            last_q <= grant[1];
        end
    end
`else
    logic unused_rr;
    assign unused_rr = clk ^ rst ^ grant_en;

    // Fixed priority: port 0 always wins a tie.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = 2'b01;
        end
    end
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer in front of the data memory
// wrapper. One access at a time: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
// Configuration macro: DMEM_ARB_RR_EN selects round-robin tie-breaking.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = CMD_ADDR_W,
    parameter int DATA_W  = CMD_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    dmem_arbiter_if.slave       r0,
    dmem_arbiter_if.slave       r1,
    output logic                mem_we_re,
    output logic                mem_request,
    output logic                mem_load,
    output logic [DATA_W/8-1:0] mem_mask,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_data_in,
    input  logic                mem_valid,
    input  logic [DATA_W-1:0]   mem_data_out
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state;
    cmd_t              cmd;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              in_idle;
    logic              timed_out;

    assign req       = {r1.req_valid, r0.req_valid};
    assign in_idle   = (state == IDLE);
    assign timed_out = (cnt == CNT_LAST);

    dmem_rr_arbiter u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant_en (in_idle),
        .grant    (grant)
    );

    // Sequencer state and command latch; the latch loads on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cmd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        state      <= ISSUE;
                        cmd.owner  <= grant[1];
                        cmd.we     <= grant[1] ? r1.we    : r0.we;
                        cmd.mask   <= grant[1] ? r1.mask  : r0.mask;
                        cmd.addr   <= grant[1] ? r1.addr  : r0.addr;
                        cmd.wdata  <= grant[1] ? r1.wdata : r0.wdata;
                    end
                end
                ISSUE:   state <= cmd.we ? RESP : WAIT;
                WAIT: begin
                    if (mem_valid || timed_out) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Load completion: capture memory data or force an error after the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q    <= 1'b0;
            cnt      <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state == ISSUE) begin
            err_q <= 1'b0;
            cnt   <= '0;
        end else if (state == WAIT) begin
            if (mem_valid) begin
                err_q <= 1'b0;
                if (cmd.owner == PORT_AUX) rdata1_q <= mem_data_out;
                else                       rdata0_q <= mem_data_out;
            end else if (timed_out) begin
                err_q <= 1'b1;
                if (cmd.owner == PORT_AUX) rdata1_q <= '0;
                else                       rdata0_q <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign mem_request = (state == ISSUE);
    assign mem_we_re   = mem_request &  cmd.we;
    assign mem_load    = mem_request & ~cmd.we;
    assign mem_mask    = cmd.mask;
    assign mem_address = cmd.addr;
    assign mem_data_in = cmd.wdata;

    assign r0.req_ready = ~rst & in_idle & grant[0];
    assign r1.req_ready = ~rst & in_idle & grant[1];

    assign r0.rsp_valid = (state == RESP) & (cmd.owner == PORT_LSU);
    assign r1.rsp_valid = (state == RESP) & (cmd.owner == PORT_AUX);
    assign r0.rsp_err   = r0.rsp_valid & err_q;
    assign r1.rsp_err   = r1.rsp_valid & err_q;
    assign r0.rdata     = rdata0_q;
    assign r1.rdata     = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter. A behavioural model
// predicts grants, memory contents and response timing; a monitor compares.
module tb_dmem_arbiter;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;
    localparam int TO_LAT  = TIMEOUT + 2;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] other;
        int          due;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [3:0]  mask;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          due;
    } iss_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_we_re, mem_request, mem_load;
    logic [3:0]  mem_mask;
    logic [7:0]  mem_address;
    logic [31:0] mem_data_in;
    logic        mem_valid;
    logic [31:0] mem_data_out = '0;
    logic        env_valid = 1'b0;
    logic        inj_valid = 1'b0;
    logic        env_init = 1'b1;
    logic        mem_stall = 1'b0;
    logic [31:0] env_mem [256];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    rsp_t rsp_q[$];
    iss_t iss_q[$];
    int   dut_grants[$];
    rsp_t mon_rsp;
    iss_t mon_iss;

    bit          pend_v     [2];
    logic        pend_we    [2];
    logic [3:0]  pend_mask  [2];
    logic [7:0]  pend_addr  [2];
    logic [31:0] pend_wdata [2];
    bit          pend_stall [2];

    int          model_free = 0;
    int          last_grant = 1;
    logic [31:0] last_rdata [2];
    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;

    assign mem_valid = env_valid | inj_valid;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r0_if ();
    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r1_if ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .r0           (r0_if),
        .r1           (r1_if),
        .mem_we_re    (mem_we_re),
        .mem_request  (mem_request),
        .mem_load     (mem_load),
        .mem_mask     (mem_mask),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_valid    (mem_valid),
        .mem_data_out (mem_data_out)
    );

    function automatic logic [31:0] init_word(int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, b, b, b} ^ 32'h5A5A5A5A;
    endfunction

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory wrapper model: byte-masked writes, registered load valid.
    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
            env_init <= 1'b0;
        end else if (mem_request && mem_we_re) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) env_mem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
        end
        env_valid <= mem_request && mem_load && !mem_stall;
        if (mem_request && mem_load) mem_data_out <= env_mem[mem_address];
    end

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check_output({tag, "_ready0"}, 32'(r0_if.req_ready), 32'd0);
        check_output({tag, "_ready1"}, 32'(r1_if.req_ready), 32'd0);
        check_output({tag, "_mem_request"}, 32'(mem_request), 32'd0);
        check_output({tag, "_mem_we_re"}, 32'(mem_we_re), 32'd0);
        check_output({tag, "_mem_load"}, 32'(mem_load), 32'd0);
        check_output({tag, "_mem_address"}, 32'(mem_address), 32'd0);
        check_output({tag, "_mem_mask"}, 32'(mem_mask), 32'd0);
        check_output({tag, "_mem_data_in"}, mem_data_in, 32'd0);
        check_output({tag, "_rsp0"}, 32'({r0_if.rsp_valid, r0_if.rsp_err}), 32'd0);
        check_output({tag, "_rsp1"}, 32'({r1_if.rsp_valid, r1_if.rsp_err}), 32'd0);
        check_output({tag, "_rdata0"}, r0_if.rdata, 32'd0);
        check_output({tag, "_rdata1"}, r1_if.rdata, 32'd0);
    endtask

    task automatic queue_req(int p, logic we, logic [3:0] mask, logic [7:0] addr,
                             logic [31:0] wdata, bit stall);
        pend_v[p]     = 1'b1;
        pend_we[p]    = we;
        pend_mask[p]  = mask;
        pend_addr[p]  = addr;
        pend_wdata[p] = wdata;
        pend_stall[p] = stall;
    endtask

    // Model an accepted request: update reference memory and queue expectations.
    task automatic accept_model(int w);
        rsp_t r;
        iss_t s;
        last_grant = w;
        pend_v[w] = 1'b0;
        s.we = pend_we[w]; s.mask = pend_mask[w]; s.addr = pend_addr[w];
        s.wdata = pend_wdata[w]; s.due = cyc + 1;
        iss_q.push_back(s);
        r.port = w;
        if (pend_we[w]) begin
            for (int b = 0; b < 4; b++)
                if (pend_mask[w][b]) ref_mem[pend_addr[w]][8*b +: 8] = pend_wdata[w][8*b +: 8];
            r.err = 1'b0;
            r.due = cyc + 2;
            model_free = cyc + 3;
        end else begin
            mem_stall = pend_stall[w];
            if (pend_stall[w]) begin
                last_rdata[w] = 32'd0;
                r.err = 1'b1;
                r.due = cyc + TO_LAT;
                model_free = cyc + TO_LAT + 1;
            end else begin
                last_rdata[w] = ref_mem[pend_addr[w]];
                r.err = 1'b0;
                r.due = cyc + 3;
                model_free = cyc + 4;
            end
        end
        r.rdata = last_rdata[w];
        r.other = last_rdata[1 - w];
        rsp_q.push_back(r);
    endtask

    // One cycle of stimulus: drive pending requests, predict and check the grant.
    task automatic apply_stimulus();
        int w;
        @(negedge clk);
        r0_if.req_valid = pend_v[0];
        r0_if.we = pend_we[0]; r0_if.mask = pend_mask[0];
        r0_if.addr = pend_addr[0]; r0_if.wdata = pend_wdata[0];
        r1_if.req_valid = pend_v[1];
        r1_if.we = pend_we[1]; r1_if.mask = pend_mask[1];
        r1_if.addr = pend_addr[1]; r1_if.wdata = pend_wdata[1];
        #1;
        w = -1;
        if (cyc >= model_free) begin
            if (pend_v[0] && pend_v[1]) begin
`ifdef DMEM_ARB_RR_EN
                w = (last_grant == 0) ? 1 : 0;
`else
                w = 0;
`endif
            end else if (pend_v[0]) begin
                w = 0;
            end else if (pend_v[1]) begin
                w = 1;
            end
        end
        if (r0_if.req_ready) dut_grants.push_back(0);
        if (r1_if.req_ready) dut_grants.push_back(1);
        check_output("ready0", 32'(r0_if.req_ready), 32'(w == 0));
        check_output("ready1", 32'(r1_if.req_ready), 32'(w == 1));
        if (w >= 0) accept_model(w);
    endtask

    task automatic drain();
        int n = 0;
        while ((pend_v[0] || pend_v[1] || rsp_q.size() != 0 || iss_q.size() != 0) && n < 200) begin
            apply_stimulus();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout actual=busy required=idle");
        end
    endtask

    // Monitor: compare every response pulse and memory strobe with the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (r0_if.rsp_valid || r1_if.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check_output("unexpected_rsp", 32'({r1_if.rsp_valid, r0_if.rsp_valid}), 32'd0);
                end else begin
                    mon_rsp = rsp_q.pop_front();
                    check_output("rsp_cycle", 32'(cyc), 32'(mon_rsp.due));
                    check_output("rsp_owner", 32'({r1_if.rsp_valid, r0_if.rsp_valid}),
                                 (mon_rsp.port == 1) ? 32'd2 : 32'd1);
                    check_output("rsp_err", 32'(mon_rsp.port == 1 ? r1_if.rsp_err : r0_if.rsp_err),
                                 32'(mon_rsp.err));
                    check_output("rsp_rdata", (mon_rsp.port == 1) ? r1_if.rdata : r0_if.rdata,
                                 mon_rsp.rdata);
                    check_output("held_rdata", (mon_rsp.port == 1) ? r0_if.rdata : r1_if.rdata,
                                 mon_rsp.other);
                end
            end else if (rsp_q.size() != 0 && rsp_q[0].due < cyc) begin
                mon_rsp = rsp_q.pop_front();
                check_output("missing_rsp", 32'(cyc), 32'(mon_rsp.due));
            end

            if (mem_request) begin
                if (iss_q.size() == 0) begin
                    check_output("unexpected_issue", 32'(mem_request), 32'd0);
                end else begin
                    mon_iss = iss_q.pop_front();
                    check_output("issue_cycle", 32'(cyc), 32'(mon_iss.due));
                    check_output("issue_we", 32'({mem_we_re, mem_load}), mon_iss.we ? 32'd2 : 32'd1);
                    check_output("issue_addr", 32'(mem_address), 32'(mon_iss.addr));
                    check_output("issue_mask", 32'(mem_mask), 32'(mon_iss.mask));
                    check_output("issue_data", mem_data_in, mon_iss.wdata);
                end
            end else if (mem_we_re || mem_load) begin
                check_output("strobe_outside_issue", 32'({mem_we_re, mem_load}), 32'd0);
            end else if (iss_q.size() != 0 && iss_q[0].due < cyc) begin
                mon_iss = iss_q.pop_front();
                check_output("missing_issue", 32'(cyc), 32'(mon_iss.due));
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: directed test-plan items, reset abort, tie handling, random traffic.
    initial begin
        int n;
        int exp_g;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        last_rdata[0] = 32'd0;
        last_rdata[1] = 32'd0;
        for (int p = 0; p < 2; p++) queue_req(p, 1'b0, 4'h0, 8'h0, 32'h0, 1'b0);
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        r0_if.req_valid = 1'b1; r0_if.we = 1'b1; r0_if.mask = 4'hF;
        r0_if.addr = 8'h55; r0_if.wdata = 32'h12345678;
        r1_if.req_valid = 1'b1; r1_if.we = 1'b0; r1_if.mask = 4'hF;
        r1_if.addr = 8'h66; r1_if.wdata = 32'h9ABCDEF0;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #2;
        rst = 1'b0;
        r0_if.req_valid = 1'b0;
        r1_if.req_valid = 1'b0;
        model_free = cyc;

        queue_req(0, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0);
        drain();
        queue_req(1, 1'b0, 4'hF, 8'h10, 32'h0, 1'b0);
        drain();
        check_output("tp_load_data", r1_if.rdata, 32'hDEADBEEF);
        check_output("tp_port0_rdata_untouched", r0_if.rdata, 32'd0);

        queue_req(0, 1'b1, 4'h0, 8'h10, 32'h01020304, 1'b0);
        drain();
        queue_req(0, 1'b0, 4'hF, 8'h10, 32'h0, 1'b0);
        drain();
        check_output("mask0_store_no_change", r0_if.rdata, 32'hDEADBEEF);

        queue_req(0, 1'b1, 4'hF, 8'h20, 32'h11223344, 1'b0);
        drain();
        queue_req(0, 1'b1, 4'b0101, 8'h20, 32'hAABBCCDD, 1'b0);
        drain();
        queue_req(0, 1'b0, 4'hF, 8'h20, 32'h0, 1'b0);
        drain();
        check_output("partial_mask_merge", r0_if.rdata, 32'h11BB33DD);

        queue_req(1, 1'b0, 4'hF, 8'h10, 32'h0, 1'b1);
        drain();
        check_output("timeout_rdata", r1_if.rdata, 32'd0);
        mem_stall = 1'b0;
        queue_req(1, 1'b0, 4'hF, 8'h20, 32'h0, 1'b0);
        drain();
        check_output("after_timeout_load", r1_if.rdata, 32'h11BB33DD);

        queue_req(0, 1'b0, 4'hF, 8'h10, 32'h0, 1'b1);
        n = 0;
        while (pend_v[0] && n < 50) begin apply_stimulus(); n++; end
        repeat (4) apply_stimulus();
        @(posedge clk); #2;
        rst = 1'b1;
        r1_if.req_valid = 1'b1;
        inj_valid = 1'b1;
        #1;
        check_reset_outputs("wait_rst");
        rsp_q.delete();
        iss_q.delete();
        @(posedge clk); #2;
        inj_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        r1_if.req_valid = 1'b0;
        last_grant = 1;
        last_rdata[0] = 32'd0;
        last_rdata[1] = 32'd0;
        mem_stall = 1'b0;
        model_free = cyc;
        @(negedge clk) inj_valid = 1'b1;
        @(negedge clk) inj_valid = 1'b0;
        repeat (4) apply_stimulus();
        check_output("late_valid_rdata0", r0_if.rdata, 32'd0);

        dut_grants.delete();
        for (int g = 0; g < 4; g++) begin
            if (!pend_v[0]) queue_req(0, 1'b1, 4'($urandom), 8'($urandom_range(0, 15)), $urandom, 1'b0);
            if (!pend_v[1]) queue_req(1, 1'b1, 4'($urandom), 8'($urandom_range(0, 15)), $urandom, 1'b0);
            n = 0;
            while (dut_grants.size() <= g && n < 50) begin apply_stimulus(); n++; end
        end
        check_output("tie_grant_count", 32'(dut_grants.size()), 32'd4);
        for (int g = 0; g < 4 && g < dut_grants.size(); g++) begin
`ifdef DMEM_ARB_RR_EN
            exp_g = g % 2;
`else
            exp_g = 0;
`endif
            check_output("tie_grant", 32'(dut_grants[g]), 32'(exp_g));
        end
        drain();

        for (int t = 0; t < 80; t++) begin
            int p;
            p = $urandom_range(0, 1);
            if (!pend_v[p])
                queue_req(p, 1'($urandom), 4'($urandom), 8'($urandom_range(0, 15)), $urandom,
                          $urandom_range(0, 5) == 0);
            apply_stimulus();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
